// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line and oversampling tick in, byte and status strobes out.
// The master modport is the receiver itself; the slave modport is the line driver/consumer.
interface uart_rx_if;
  logic       s_tick;
  logic       rx;
  logic [7:0] data_out;
  logic       rx_done_tick;
  logic       frame_err;
  logic       busy;

  modport master (
    input  s_tick,
    input  rx,
    output data_out,
    output rx_done_tick,
    output frame_err,
    output busy
  );

  modport slave (
    output s_tick,
    output rx,
    input  data_out,
    input  rx_done_tick,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver (start, DBIT data bits LSB first, stop) with
// false-start rejection and framing-error detection.
module uart_rx #(
  parameter int DBIT          = 8,
  parameter int S_TICK_LIM    = 16,
  parameter int STOP_BITS_LIM = 16
) (
  input  logic      clk,
  input  logic      reset,
  uart_rx_if.master bus
);

  localparam logic [4:0] MID_TICK  = 5'(S_TICK_LIM / 2 - 1);
  localparam logic [4:0] BIT_TICK  = 5'(S_TICK_LIM - 1);
  localparam logic [4:0] STOP_TICK = 5'(STOP_BITS_LIM - 1);
  localparam logic [2:0] LAST_BIT  = 3'(DBIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t     state_reg, state_next;
  logic [4:0] tick_reg, tick_next;
  logic [2:0] bit_reg, bit_next;
  logic [7:0] shift_reg, shift_next;
  logic [7:0] data_reg, data_next;
  logic       done_reg, done_next;
  logic       ferr_reg, ferr_next;
  logic       armed_reg, armed_next;
  logic       sync_reg;
  logic       rx_s_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      tick_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      data_reg  <= '0;
      done_reg  <= 1'b0;
      ferr_reg  <= 1'b0;
      armed_reg <= 1'b1;
      sync_reg  <= 1'b1;
      rx_s_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      tick_reg  <= tick_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      data_reg  <= data_next;
      done_reg  <= done_next;
      ferr_reg  <= ferr_next;
      armed_reg <= armed_next;
      sync_reg  <= bus.rx;
      rx_s_reg  <= sync_reg;
    end
  end

  always_comb begin
    state_next = state_reg;
    tick_next  = tick_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    data_next  = data_reg;
    done_next  = 1'b0;
    ferr_next  = 1'b0;
    // A held-low line must go high once after a framing error before a new start is accepted.
    armed_next = armed_reg | rx_s_reg;
    case (state_reg)
      IDLE: begin
        if (!rx_s_reg && armed_reg) begin
          tick_next  = '0;
          state_next = START;
        end
      end
      START: begin
        if (bus.s_tick) begin
          if (tick_reg == MID_TICK) begin
            if (rx_s_reg) begin
              state_next = IDLE;
            end else begin
              tick_next  = '0;
              bit_next   = '0;
              state_next = DATA;
            end
          end else begin
            tick_next = tick_reg + 5'd1;
          end
        end
      end
      DATA: begin
        if (bus.s_tick) begin
          if (tick_reg == BIT_TICK) begin
            tick_next  = '0;
            shift_next = {rx_s_reg, shift_reg[7:1]};
            if (bit_reg == LAST_BIT) begin
              state_next = STOP;
            end else begin
              bit_next = bit_reg + 3'd1;
            end
          end else begin
            tick_next = tick_reg + 5'd1;
          end
        end
      end
      STOP: begin
        if (bus.s_tick) begin
          if (tick_reg == STOP_TICK) begin
            state_next = IDLE;
            if (rx_s_reg) begin
              // Short frames land in the upper bits of the shifter; right-align them.
              data_next = shift_reg >> (8 - DBIT);
              done_next = 1'b1;
            end else begin
              ferr_next  = 1'b1;
              armed_next = 1'b0;
            end
          end else begin
            tick_next = tick_reg + 5'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.data_out     = data_reg;
  assign bus.rx_done_tick = done_reg;
  assign bus.frame_err    = ferr_reg;
  assign bus.busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: two instances (8N1 and 7-bit/2-stop), randomized frames,
// expected bytes/errors queued at send time and popped by per-instance monitors.
module tb_uart_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_a;
  logic reset_b;

  uart_rx_if bus_a ();
  uart_rx_if bus_b ();

  uart_rx #(.DBIT(8), .S_TICK_LIM(16), .STOP_BITS_LIM(16)) dut_a (
    .clk   (clk),
    .reset (reset_a),
    .bus   (bus_a.master)
  );

  uart_rx #(.DBIT(7), .S_TICK_LIM(16), .STOP_BITS_LIM(32)) dut_b (
    .clk   (clk),
    .reset (reset_b),
    .bus   (bus_b.master)
  );

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_a[$];
  exp_t       exp_b[$];
  logic [7:0] last_good[2];
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // s_tick: one clk pulse every 4 clocks, shared by both receivers
  initial begin
    int cnt;
    cnt = 0;
    bus_a.s_tick = 1'b0;
    bus_b.s_tick = 1'b0;
    forever begin
      @(negedge clk);
      cnt = (cnt + 1) % 4;
      bus_a.s_tick = (cnt == 0);
      bus_b.s_tick = (cnt == 0);
    end
  end

  task automatic on_strobe(input int sel, input logic done, input logic ferr, input logic [7:0] dout);
    exp_t e;
    check($sformatf("strobe_exclusive_%0d", sel), 32'(done & ferr), 32'd0);
    if ((sel == 0 && exp_a.size() == 0) || (sel == 1 && exp_b.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL unexpected_strobe_%0d done=%0b frame_err=%0b data_out=0x%0h required=none",
               sel, done, ferr, dout);
    end else begin
      e = (sel == 0) ? exp_a.pop_front() : exp_b.pop_front();
      check($sformatf("strobe_kind_%0d", sel), 32'(ferr), 32'(e.is_err));
      check($sformatf("data_out_%0d", sel), 32'(dout), 32'(e.data));
      $display("dut%0d %s data_out=0x%02h expected=0x%02h", sel,
               ferr ? "frame_err" : "rx_done", dout, e.data);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (bus_a.rx_done_tick === 1'b1 || bus_a.frame_err === 1'b1)
        on_strobe(0, bus_a.rx_done_tick, bus_a.frame_err, bus_a.data_out);
      if (bus_b.rx_done_tick === 1'b1 || bus_b.frame_err === 1'b1)
        on_strobe(1, bus_b.rx_done_tick, bus_b.frame_err, bus_b.data_out);
    end
  end

  task automatic drive(input int sel, input logic v, input int cycles);
    if (sel == 0) bus_a.rx = v;
    else bus_b.rx = v;
    repeat (cycles) @(negedge clk);
  endtask

  // Model: a good stop yields the low DBIT bits; a bad stop yields frame_err with the old byte.
  task automatic send_frame(input int sel, input logic [7:0] value, input bit good, input int bit_cyc);
    int   nbits;
    int   nstop;
    exp_t e;
    nbits = (sel == 0) ? 8 : 7;
    nstop = (sel == 0) ? 1 : 2;
    e.is_err = !good;
    if (good) last_good[sel] = value & 8'((1 << nbits) - 1);
    e.data = last_good[sel];
    if (sel == 0) exp_a.push_back(e);
    else exp_b.push_back(e);
    drive(sel, 1'b0, bit_cyc);
    for (int i = 0; i < nbits; i++) drive(sel, value[i], bit_cyc);
    drive(sel, good ? 1'b1 : 1'b0, nstop * bit_cyc);
  endtask

  function automatic int rand_bit_cyc();
    return int'($urandom_range(62, 66));
  endfunction

  initial begin
    logic [7:0] v;
    bit         good;
    int         waited;
    last_good[0] = 8'h00;
    last_good[1] = 8'h00;
    reset_a  = 1'b1;
    reset_b  = 1'b1;
    bus_a.rx = 1'b1;
    bus_b.rx = 1'b1;
    repeat (4) @(negedge clk);
    reset_a = 1'b0;
    reset_b = 1'b0;

    // idle after reset: 100 ticks of a high line
    repeat (400) @(negedge clk);
    check("idle_busy_a", 32'(bus_a.busy), 32'd0);
    check("idle_done_a", 32'(bus_a.rx_done_tick), 32'd0);
    check("idle_data_a", 32'(bus_a.data_out), 32'h00);
    check("idle_busy_b", 32'(bus_b.busy), 32'd0);
    check("idle_ferr_b", 32'(bus_b.frame_err), 32'd0);
    check("idle_data_b", 32'(bus_b.data_out), 32'h00);

    send_frame(0, 8'h55, 1'b1, 64);
    drive(0, 1'b1, 64);

    // back-to-back, no idle gap
    send_frame(0, 8'hA3, 1'b1, rand_bit_cyc());
    send_frame(0, 8'h00, 1'b1, rand_bit_cyc());
    send_frame(0, 8'hFF, 1'b1, rand_bit_cyc());
    drive(0, 1'b1, 64);

    // glitch: low for 5 ticks, then high; must be idle again by the 8th tick
    drive(0, 1'b0, 10);
    check("glitch_busy_started", 32'(bus_a.busy), 32'd1);
    drive(0, 1'b0, 10);
    drive(0, 1'b1, 20);
    check("glitch_busy_cleared", 32'(bus_a.busy), 32'd0);
    drive(0, 1'b1, 64);
    send_frame(0, 8'h3C, 1'b1, 64);
    drive(0, 1'b1, 64);

    // framing error followed by a break; no re-arm until the line goes high
    send_frame(0, 8'h81, 1'b0, 64);
    drive(0, 1'b0, 192);
    check("break_not_rearmed", 32'(bus_a.busy), 32'd0);
    drive(0, 1'b1, 128);
    check("break_released_idle", 32'(bus_a.busy), 32'd0);

    // reset during data bit 4
    drive(0, 1'b0, 64);
    v = 8'h99;
    for (int i = 0; i < 4; i++) drive(0, v[i], 64);
    drive(0, v[4], 32);
    check("pre_reset_busy", 32'(bus_a.busy), 32'd1);
    reset_a  = 1'b1;
    bus_a.rx = 1'b1;
    @(negedge clk);
    check("reset_busy_cleared", 32'(bus_a.busy), 32'd0);
    reset_a = 1'b0;
    drive(0, 1'b1, 128);
    check("post_reset_idle", 32'(bus_a.busy), 32'd0);
    send_frame(0, 8'hC6, 1'b1, 64);
    drive(0, 1'b1, 64);

    // randomized traffic on the 8-bit receiver
    for (int n = 0; n < 15; n++) begin
      v    = 8'($urandom);
      good = ($urandom_range(0, 4) != 0);
      send_frame(0, v, good, rand_bit_cyc());
      if (!good) drive(0, 1'b1, 64 + int'($urandom_range(0, 40)));
      else drive(0, 1'b1, int'($urandom_range(0, 40)));
    end

    // 7 data bits, 2 stop bits
    send_frame(1, 8'h5A, 1'b1, 64);
    drive(1, 1'b1, 64);
    for (int n = 0; n < 6; n++) begin
      v    = 8'($urandom) & 8'h7F;
      good = ($urandom_range(0, 3) != 0);
      send_frame(1, v, good, rand_bit_cyc());
      if (!good) drive(1, 1'b1, 64 + int'($urandom_range(0, 40)));
      else drive(1, 1'b1, int'($urandom_range(0, 40)));
    end

    waited = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("pending_a", 32'(exp_a.size()), 32'd0);
    check("pending_b", 32'(exp_b.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: deserialises an asynchronous 8N1-style serial line into parallel bytes.
- Oversamples the line using the shared baud tick s_tick at 16 ticks per bit. That tick comes from the same baud generator that drives the transmitter.
- Output is a one-cycle data-valid strobe plus status flags, consumed by the command/FIFO logic downstream.
- Includes a 2-flop input synchroniser, mid-bit sampling, false-start rejection and framing-error detection.

Parameters:
- DBIT, 8, number of data bits per frame, 5..8, LSB first.
- S_TICK_LIM, 16, s_tick pulses per bit period; sampling point is S_TICK_LIM/2 - 1.
- STOP_BITS_LIM, 16, s_tick pulses for the stop period (16 = 1 bit, 24 = 1.5 bits, 32 = 2 bits).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset; clock clk.
- s_tick  input  1  single-cycle oversampling enable, S_TICK_LIM pulses per bit.
- rx  input  1  asynchronous serial line, idle high.
- data_out  output  8  received byte; unused MSBs are 0 when DBIT<8; holds its value until the next valid frame.
- rx_done_tick  output  1  one-cycle strobe: frame received, data_out valid.
- frame_err  output  1  one-cycle strobe: stop bit sampled low.
- busy  output  1  high while state != idle.

Behaviour:
- Synchroniser: rx passes through two flops (rx_s) before all logic. Both flops reset to 1.
- Counters: tick counter 5 bits; bit counter 3 bits; shift register 8 bits.
- Reset values: state=idle, data_out=0, rx_done_tick=0, frame_err=0, busy=0, counters=0, shift register=0, synchroniser flops=1.
- Reset mid-frame: abort immediately, no strobe, return to idle.
- idle:
  - On rx_s==0, clear the tick counter and go to start. This does not wait for s_tick.
- start:
  - On each s_tick, increment the tick counter.
  - When the counter reaches S_TICK_LIM/2-1 (mid-start-bit), resample.
  - rx_s==1: glitch, return to idle with no strobe.
  - rx_s==0: clear the tick counter, clear the bit counter, go to data.
- data:
  - On each s_tick, increment the tick counter.
  - At S_TICK_LIM-1 (mid-bit), shift rx_s into the MSB side of the shift register (shift right), clear the tick counter and increment the bit counter.
  - After bit DBIT-1 is sampled, go to stop.
- stop:
  - Count s_tick to STOP_BITS_LIM-1, which samples at the middle of the first stop bit for STOP_BITS_LIM=16.
  - At that point, return to idle and evaluate the stop bit:
    - rx_s==1: data_out <= shift register right-aligned (shifted by 8-DBIT), and rx_done_tick pulses for exactly one clk.
    - rx_s==0: frame_err pulses for one clk, and data_out is unchanged.
- Strobes: rx_done_tick and frame_err are never high together. Each is registered and asserts the cycle after the sampling s_tick.
- Simultaneous events:
  - s_tick arriving in the same cycle as the idle→start transition is not counted.
  - A line held low (break) produces frame_err. The block then stays idle until rx_s returns high and falls again.
  - To enforce this, the idle state must see rx_s==1 at least once after a frame_err before re-arming.
- Back-to-back frames: a start edge immediately after the stop sample is accepted, giving no dead time beyond one clk.
- Latency: rx_done_tick asserts about 9.5 bit periods after the start-bit falling edge (16x, DBIT=8), plus 2 clk of synchroniser delay plus 1 clk of registering.
- Tick-rate tolerance: correct reception is required with up to ±3% baud mismatch.

Test Plan:
- Reset and idle: hold rx=1 for 100 ticks after reset -> busy=0, rx_done_tick=0, data_out=0x00.
- Single frame: send 0x55 at 16x (start, 1010_1010 LSB first, stop) -> exactly one rx_done_tick, data_out=0x55, frame_err=0.
- Back-to-back frames: send 0xA3 then 0x00 then 0xFF with no idle gap -> three rx_done_tick pulses, data_out sequence A3, 00, FF.
- Glitch rejection: drive rx low for 5 s_tick periods then high -> no strobe, busy returns 0 by tick 8, and a subsequent 0x3C is received correctly.
- Framing error: send 0x81 with the stop bit driven low -> frame_err pulses once, rx_done_tick stays 0, data_out keeps its previous value. Holding rx low afterwards causes no further strobes until rx goes high.
- Reset mid-frame plus parameter check: assert reset during data bit 4 -> no strobe, busy=0 next cycle, and the next 0xC6 is received. Repeat with DBIT=7 and STOP_BITS_LIM=32, sending 0x5A -> data_out=0x5A, one rx_done_tick.
